// File: rtl/dcache_read_ctrl.sv
// rtl/dcache_read_ctrl.sv - direct-mapped read-only data cache between core load port and block memory
//
// Serves 32-bit word loads from 16-byte lines. A miss issues one aligned
// 128-bit block read, fills the line, then returns the requested word.
//
// Optional feature macro: DCACHE_STATS_EN (adds stat_hits / stat_misses).
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-low reset
//   cpu_req        load request, held until cpu_rvalid
//   cpu_addr       byte address of the load (bits [1:0] ignored)
//   cpu_flush      invalidate all lines (only acted on in IDLE)
//   cpu_busy       high whenever the controller is not IDLE
//   cpu_rvalid     one-cycle pulse, cpu_rdata valid
//   cpu_rdata      load data, holds its value outside the response cycle
//   mem_read       one-cycle block read strobe
//   mem_address    16-byte aligned block address
//   mem_block_out  block returned by data memory, byte k at [8k+7:8k]
//   stat_hits      (DCACHE_STATS_EN) lookup hit count
//   stat_misses    (DCACHE_STATS_EN) lookup miss count

module dcache_read_ctrl #(
  parameter int NUM_LINES   = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic [31:0]  cpu_addr,
  input  logic         cpu_flush,
  output logic         cpu_busy,
  output logic         cpu_rvalid,
  output logic [31:0]  cpu_rdata,
  output logic         mem_read,
  output logic [31:0]  mem_address,
  input  logic [127:0] mem_block_out
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  stat_hits,
  output logic [31:0]  stat_misses
`endif
);

  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = 28 - IDX_BITS;
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t               state;
  logic [31:2]          req_addr;
  logic [3:0]           wait_cnt;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
  logic [127:0]         data_mem [NUM_LINES];

  logic [IDX_BITS-1:0]  req_idx;
  logic [TAG_BITS-1:0]  req_tag;
  logic [1:0]           req_word;
  logic                 hit;
  logic                 fill_en;
  logic                 unused_addr_bits;

  assign req_idx  = req_addr[4+IDX_BITS-1:4];
  assign req_tag  = req_addr[31:4+IDX_BITS];
  assign req_word = req_addr[3:2];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  // The last WAIT cycle is the one where the memory block is guaranteed stable.
  assign fill_en  = (state == S_WAIT) && (wait_cnt == 4'd1);
  assign cpu_busy = (state != S_IDLE);

  // Byte offset within the word never matters for word loads.
  assign unused_addr_bits = ^cpu_addr[1:0];

  function automatic logic [31:0] pick_word(input logic [127:0] blk, input logic [1:0] w);
    logic [31:0] r;
    case (w)
      2'd0:    r = blk[31:0];
      2'd1:    r = blk[63:32];
      2'd2:    r = blk[95:64];
      default: r = blk[127:96];
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      valid       <= '0;
      req_addr    <= '0;
      wait_cnt    <= '0;
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
      mem_read    <= 1'b0;
      mem_address <= '0;
`ifdef DCACHE_STATS_EN
      stat_hits   <= '0;
      stat_misses <= '0;
`endif
    end else begin
      cpu_rvalid <= 1'b0;
      mem_read   <= 1'b0;
      case (state)
        S_IDLE: begin
          // Flush takes priority; a simultaneous request waits a cycle.
          if (cpu_flush) begin
            valid <= '0;
          end else if (cpu_req) begin
            req_addr <= cpu_addr[31:2];
            state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            cpu_rdata  <= pick_word(data_mem[req_idx], req_word);
            cpu_rvalid <= 1'b1;
            state      <= S_RESPOND;
`ifdef DCACHE_STATS_EN
            stat_hits  <= stat_hits + 32'd1;
`endif
          end else begin
            // Strobe and address are registered so they appear in REFILL.
            mem_read    <= 1'b1;
            mem_address <= {req_addr[31:4], 4'b0000};
            state       <= S_REFILL;
`ifdef DCACHE_STATS_EN
            stat_misses <= stat_misses + 32'd1;
`endif
          end
        end
        S_REFILL: begin
          wait_cnt <= LAT;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (fill_en) begin
            valid[req_idx] <= 1'b1;
            cpu_rdata      <= pick_word(mem_block_out, req_word);
            cpu_rvalid     <= 1'b1;
            state          <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Line storage needs no reset: the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (reset && fill_en) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= mem_block_out;
    end
  end

endmodule

// File: tb/tb_dcache_read_ctrl.sv
// tb/tb_dcache_read_ctrl.sv - self-checking bench for dcache_read_ctrl

module tb_dcache_read_ctrl;

  localparam int NL  = 8;
  localparam int LAT = 1;
  localparam logic [127:0] GARBAGE = {4{32'hDEADBEEF}};

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cpu_req = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic         cpu_flush = 1'b0;
  logic         cpu_busy;
  logic         cpu_rvalid;
  logic [31:0]  cpu_rdata;
  logic         mem_read;
  logic [31:0]  mem_address;
  logic [127:0] mem_block_out;
`ifdef DCACHE_STATS_EN
  logic [31:0]  stat_hits;
  logic [31:0]  stat_misses;
`endif

  always #5 clk = ~clk;

  dcache_read_ctrl #(.NUM_LINES(NL), .MEM_LATENCY(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .cpu_req(cpu_req),
    .cpu_addr(cpu_addr),
    .cpu_flush(cpu_flush),
    .cpu_busy(cpu_busy),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .mem_read(mem_read),
    .mem_address(mem_address),
    .mem_block_out(mem_block_out)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits(stat_hits),
    .stat_misses(stat_misses)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit mem_mode = 1'b0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Reference cache: which block (address >> 4) each index holds.
  logic [27:0] m_line [NL];
  bit          m_valid [NL];

  // Memory contents: mode 0 is the preload pattern, mode 1 a hashed pattern.
  function automatic logic [31:0] mem_word(input bit mode, input logic [31:0] a);
    if (mode == 1'b0)
      return (a < 32'd32) ? ((a >> 2) + 32'd1) : 32'd0;
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic logic [127:0] mem_block(input bit mode, input logic [31:0] a);
    logic [127:0] b;
    for (int w = 0; w < 4; w++)
      b[32*w +: 32] = mem_word(mode, {a[31:4], 4'b0000} + 32'(4 * w));
    return b;
  endfunction

  // Block memory: the block is present only in the cycle it must be sampled.
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  always @(posedge clk) begin
    if (!reset) begin
      pend_cnt      <= 0;
      mem_block_out <= GARBAGE;
    end else if (mem_read) begin
      pend_addr <= mem_address;
      if (LAT == 1) begin
        mem_block_out <= mem_block(mem_mode, mem_address);
        pend_cnt      <= 0;
      end else begin
        mem_block_out <= GARBAGE;
        pend_cnt      <= LAT - 1;
      end
    end else if (pend_cnt == 1) begin
      mem_block_out <= mem_block(mem_mode, pend_addr);
      pend_cnt      <= 0;
    end else begin
      mem_block_out <= GARBAGE;
      if (pend_cnt > 1) pend_cnt <= pend_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " busy"}, 32'(cpu_busy), 32'd0);
    check({name, " rvalid"}, 32'(cpu_rvalid), 32'd0);
    check({name, " rdata"}, cpu_rdata, 32'd0);
    check({name, " mem_read"}, 32'(mem_read), 32'd0);
    check({name, " mem_address"}, mem_address, 32'd0);
`ifdef DCACHE_STATS_EN
    check({name, " stat_hits"}, stat_hits, 32'd0);
    check({name, " stat_misses"}, stat_misses, 32'd0);
`endif
  endtask

  task automatic check_stats(input string name);
`ifdef DCACHE_STATS_EN
    check({name, " stat_hits"}, stat_hits, 32'(exp_hits));
    check({name, " stat_misses"}, stat_misses, 32'(exp_misses));
`else
    n_cmp = n_cmp + 0;
    if (name.len() == 0) $display("empty stats tag");
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    cpu_req = 1'b0;
    cpu_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    model_clear();
  endtask

  // Issue one load and watch it until cpu_rvalid (bounded).
  task automatic do_load(input logic [31:0] addr, output logic [31:0] rdata, output int lat,
                         output int nreads, output logic [31:0] maddr, output bit busy_ok);
    @(negedge clk);
    cpu_addr = addr;
    cpu_req = 1'b1;
    cpu_flush = 1'b0;
    lat = 0;
    nreads = 0;
    maddr = '0;
    busy_ok = 1'b1;
    rdata = '0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (!cpu_busy) busy_ok = 1'b0;
      if (mem_read) begin
        nreads++;
        maddr = mem_address;
      end
      cpu_addr = $urandom;
      if (cpu_rvalid) begin
        lat = c;
        rdata = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic check_load(input logic [31:0] addr, input bit exp_hit,
                            input logic [31:0] exp_data, input string name);
    logic [31:0] rdata, maddr;
    int lat, nreads;
    bit busy_ok;
    do_load(addr, rdata, lat, nreads, maddr, busy_ok);
    check({name, " rdata"}, rdata, exp_data);
    check({name, " latency"}, 32'(lat), exp_hit ? 32'd2 : 32'(3 + LAT));
    check({name, " mem_reads"}, 32'(nreads), exp_hit ? 32'd0 : 32'd1);
    if (!exp_hit) check({name, " mem_address"}, maddr, {addr[31:4], 4'b0000});
    check({name, " busy"}, 32'(busy_ok), 32'd1);
    @(posedge clk);
    #1;
    check({name, " rvalid_pulse"}, 32'(cpu_rvalid), 32'd0);
    check({name, " rdata_hold"}, cpu_rdata, exp_data);
    if (exp_hit) exp_hits++;
    else exp_misses++;
  endtask

  // Reference lookup from the cache rules; updates the model on a miss.
  task automatic model_access(input logic [31:0] addr, output bit hit, output logic [31:0] data);
    int idx;
    idx = int'((addr >> 4) % NL);
    hit = m_valid[idx] && (m_line[idx] == addr[31:4]);
    data = mem_word(mem_mode, {addr[31:2], 2'b00});
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_line[idx] = addr[31:4];
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          hit;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr, data;
    bit hit;
    int pulses;

    tbl[0]  = '{32'h0000_0004, 1'b0, 32'd2};
    tbl[1]  = '{32'h0000_0008, 1'b1, 32'd3};
    tbl[2]  = '{32'h0000_001C, 1'b0, 32'd8};
    tbl[3]  = '{32'h0000_0010, 1'b1, 32'd5};
    tbl[4]  = '{32'h0000_0080, 1'b0, 32'd0};
    tbl[5]  = '{32'h0000_0000, 1'b0, 32'd1};
    tbl[6]  = '{32'h0000_0004, 1'b1, 32'd2};
    tbl[7]  = '{32'h0000_001C, 1'b1, 32'd8};
    tbl[8]  = '{32'h8000_0000, 1'b0, 32'd0};
    tbl[9]  = '{32'h0000_0000, 1'b0, 32'd1};
    tbl[10] = '{32'h0000_0003, 1'b1, 32'd1};
    tbl[11] = '{32'h0000_000F, 1'b1, 32'd4};

    mem_mode = 1'b0;
    apply_reset();

    for (int i = 0; i < 12; i++)
      check_load(tbl[i].addr, tbl[i].hit, tbl[i].data, $sformatf("vec%0d", i));
    check_stats("table");

    // Flush and request together: only the flush happens.
    check_load(32'h0, 1'b1, 32'd1, "pre_flush");
    @(negedge clk);
    cpu_addr = 32'h0;
    cpu_req = 1'b1;
    cpu_flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_no_accept busy", 32'(cpu_busy), 32'd0);
    cpu_flush = 1'b0;
    check_load(32'h0, 1'b0, 32'd1, "after_flush");

    // Reset while the refill is waiting for memory.
    @(negedge clk);
    cpu_addr = 32'h0000_0084;
    cpu_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midreset mem_read", 32'(mem_read), 32'd1);
    @(posedge clk);
    #1;
    check("midreset in_wait busy", 32'(cpu_busy), 32'd1);
    reset = 1'b0;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    reset = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (cpu_rvalid) pulses++;
    end
    check("midreset no_rvalid", 32'(pulses), 32'd0);
    check_load(32'h0000_0004, 1'b0, 32'd2, "post_reset");
    check_stats("post_reset");

    // Randomised loads against the reference model with hashed memory.
    mem_mode = 1'b1;
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      addr = (32'($urandom_range(0, 2)) << 7) | (32'($urandom_range(0, NL - 1)) << 4)
             | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) addr[31] = 1'b1;
      case ($urandom_range(0, 11))
        0: begin
          @(negedge clk);
          cpu_flush = 1'b1;
          @(posedge clk);
          #1;
          check("rnd flush busy", 32'(cpu_busy), 32'd0);
          cpu_flush = 1'b0;
          model_clear();
        end
        1: begin
          @(negedge clk);
          cpu_addr = addr;
          cpu_req = 1'b1;
          cpu_flush = 1'b1;
          @(posedge clk);
          #1;
          check("rnd flush_req busy", 32'(cpu_busy), 32'd0);
          cpu_flush = 1'b0;
          model_clear();
        end
        default: ;
      endcase
      model_access(addr, hit, data);
      check_load(addr, hit, data, $sformatf("rnd%0d@%h", i, addr));
    end
    check_stats("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
